// File: rtl/deser_arbiter.sv
// deser_arbiter: round-robin owner of one shared serial deserializer.
// Optional idle timeout/abort enabled by defining DESER_ARB_TIMEOUT_EN.
module deser_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         data_i,
  input  logic [NUM_REQ-1:0]         data_val_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       ser_data_o,
  output logic                       ser_data_val_o,
  output logic                       deser_srst_o,
  output logic                       word_done_o,
  output logic [$clog2(NUM_REQ)-1:0] last_owner_o,
  output logic                       abort_o
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be 2..8");
  end
  if (WORD_W < 1 || WORD_W > 31) begin : g_bad_word_w
    $error("WORD_W must fit the 5-bit bit counter");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_GRANT
`ifdef DESER_ARB_TIMEOUT_EN
    , S_ABORT
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [ID_W-1:0]     last_owner_q, last_owner_d;
  logic                srst_q, srst_d;

`ifdef DESER_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                abort_q, abort_d;
`endif

  logic                in_grant;
  logic                own_val;
  logic                last_bit;
  logic [ID_W-1:0]     owner_nxt;
  logic                pick_vld;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W:0]       idx;

  // Owner lane is forwarded straight through while granted.
  always_comb begin
    in_grant       = (state_q == S_GRANT);
    own_val        = in_grant & data_val_i[owner_q];
    ser_data_val_o = own_val;
    ser_data_o     = in_grant & data_i[owner_q];
    last_bit       = (bit_cnt_q == 5'(WORD_W - 1));
    word_done_o    = own_val & last_bit;
    if (owner_q == ID_W'(NUM_REQ - 1)) begin
      owner_nxt = '0;
    end else begin
      owner_nxt = owner_q + ID_W'(1);
    end
  end

  // First requesting lane at or after rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_q} + (ID_W + 1)'(i);
      if (idx >= (ID_W + 1)'(NUM_REQ)) begin
        idx = idx - (ID_W + 1)'(NUM_REQ);
      end
      if (!pick_vld && req_i[idx[ID_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = idx[ID_W-1:0];
      end
    end
  end

  // Next-state and registered-output logic of the grant FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    bit_cnt_d    = bit_cnt_q;
    last_owner_d = last_owner_q;
    srst_d       = 1'b0;
`ifdef DESER_ARB_TIMEOUT_EN
    idle_d       = idle_q;
    abort_d      = 1'b0;
`endif
    case (state_q)
      S_INIT: begin
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (pick_vld) begin
          state_d   = S_GRANT;
          grant_d   = NUM_REQ'(1) << pick_id;
          owner_d   = pick_id;
          bit_cnt_d = '0;
`ifdef DESER_ARB_TIMEOUT_EN
          idle_d    = '0;
`endif
        end
      end
      S_GRANT: begin
        if (own_val) begin
`ifdef DESER_ARB_TIMEOUT_EN
          idle_d = '0;
`endif
          if (last_bit) begin
            state_d      = S_IDLE;
            grant_d      = '0;
            bit_cnt_d    = '0;
            last_owner_d = owner_q;
            rr_d         = owner_nxt;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
`ifdef DESER_ARB_TIMEOUT_EN
        else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
          state_d   = S_ABORT;
          grant_d   = '0;
          bit_cnt_d = '0;
          rr_d      = owner_nxt;
          idle_d    = '0;
          abort_d   = 1'b1;
          srst_d    = 1'b1;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
`endif
      end
`ifdef DESER_ARB_TIMEOUT_EN
      S_ABORT: begin
        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // State and output registers; reset re-initialises the deserializer.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= S_INIT;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_q         <= '0;
      bit_cnt_q    <= '0;
      last_owner_q <= '0;
      srst_q       <= 1'b1;
`ifdef DESER_ARB_TIMEOUT_EN
      idle_q       <= '0;
      abort_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      bit_cnt_q    <= bit_cnt_d;
      last_owner_q <= last_owner_d;
      srst_q       <= srst_d;
`ifdef DESER_ARB_TIMEOUT_EN
      idle_q       <= idle_d;
      abort_q      <= abort_d;
`endif
    end
  end

  assign grant_o      = grant_q;
  assign deser_srst_o = srst_q;
  assign last_owner_o = last_owner_q;
`ifdef DESER_ARB_TIMEOUT_EN
  assign abort_o      = abort_q;
`else
  assign abort_o      = 1'b0;
`endif

endmodule
